// File: rtl/access_controller_pkg.sv
// Shared types and constants for the keycard/PIN access controller.
package access_pkg;

  localparam int unsigned STATE_W = 3;

  localparam int unsigned DEF_PIN_DIGITS    = 4;
  localparam int unsigned DEF_DIGIT_W       = 4;
  localparam int unsigned DEF_MAX_TRIES     = 3;
  localparam int unsigned DEF_ENTRY_CYCLES  = 1000;
  localparam int unsigned DEF_UNLOCK_CYCLES = 500;

  typedef enum logic [STATE_W-1:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_ALARM    = 3'd3
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One timer serves both entry and unlock phases, so it is sized for the longer one.
  function automatic int unsigned timer_width(input int unsigned entry_cycles,
                                              input int unsigned unlock_cycles);
    return $clog2(max_u(entry_cycles, unlock_cycles) + 1);
  endfunction

endpackage

// File: rtl/access_controller_if.sv
// Front-end / actuator signal bundle for the access controller.
interface access_controller_if #(
  parameter int unsigned PIN_DIGITS = access_pkg::DEF_PIN_DIGITS,
  parameter int unsigned DIGIT_W    = access_pkg::DEF_DIGIT_W,
  parameter int unsigned MAX_TRIES  = access_pkg::DEF_MAX_TRIES
);
  import access_pkg::*;

  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);

  logic                          kc;
  logic                          digit_valid;
  logic [DIGIT_W-1:0]            digit;
  logic [PIN_DIGITS*DIGIT_W-1:0] pin_code;
  logic                          arm;
  logic                          alarm_clr;
  logic                          lock;
  logic                          al;
  logic [STATE_W-1:0]            state;
  logic [FAIL_W-1:0]             fail_cnt;

  modport master (
    output kc, digit_valid, digit, pin_code, arm, alarm_clr,
    input  lock, al, state, fail_cnt
  );

  modport slave (
    input  kc, digit_valid, digit, pin_code, arm, alarm_clr,
    output lock, al, state, fail_cnt
  );

endinterface

// File: rtl/access_timer.sv
// Loadable down-counter; flags expiry while holding 1, stops at 0.
module access_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  // Count down from the loaded value; a load always overrides the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt == WIDTH'(1));

endmodule

// File: rtl/access_controller.sv
// Keycard + PIN sequencing controller driving door lock and alarm with lockout.
module access_controller
  import access_pkg::*;
#(
  parameter int unsigned PIN_DIGITS    = DEF_PIN_DIGITS,
  parameter int unsigned DIGIT_W       = DEF_DIGIT_W,
  parameter int unsigned MAX_TRIES     = DEF_MAX_TRIES,
  parameter int unsigned ENTRY_CYCLES  = DEF_ENTRY_CYCLES,
  parameter int unsigned UNLOCK_CYCLES = DEF_UNLOCK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  access_controller_if.slave bus
);

  localparam int unsigned PIN_W  = PIN_DIGITS * DIGIT_W;
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned CNT_W  = $clog2(PIN_DIGITS + 1);
  localparam int unsigned TMR_W  = timer_width(ENTRY_CYCLES, UNLOCK_CYCLES);

  state_t             state_q, state_d;
  logic [PIN_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               lock_q, al_q;

  logic [PIN_W-1:0]   shifted;
  logic               last_digit;
  logic [FAIL_W-1:0]  fail_inc;
  logic               fail_attempt;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expired;

  access_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign shifted    = (shift_q << DIGIT_W) | PIN_W'(bus.digit);
  assign last_digit = (count_q == CNT_W'(PIN_DIGITS - 1));
  assign fail_inc   = (fail_q == FAIL_W'(MAX_TRIES)) ? fail_q : fail_q + FAIL_W'(1);

  // Next-state logic: priorities are kc > completing digit > entry timeout > partial digit.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    fail_d       = fail_q;
    fail_attempt = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    case (state_q)
      ST_LOCKED: begin
        if (bus.kc) begin
          state_d  = ST_ENTRY;
          shift_d  = '0;
          count_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ENTRY_CYCLES);
        end
      end

      ST_ENTRY: begin
        if (bus.kc) begin
          shift_d  = '0;
          count_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ENTRY_CYCLES);
        end else if (bus.digit_valid && last_digit) begin
          if (shifted == bus.pin_code) begin
            state_d  = ST_UNLOCKED;
            shift_d  = '0;
            count_d  = '0;
            fail_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(UNLOCK_CYCLES);
          end else begin
            fail_attempt = 1'b1;
          end
        end else if (tmr_expired) begin
          fail_attempt = 1'b1;
        end else if (bus.digit_valid) begin
          shift_d = shifted;
          count_d = count_q + CNT_W'(1);
        end
      end

      ST_UNLOCKED: begin
        if (bus.arm || tmr_expired) begin
          state_d  = ST_LOCKED;
          tmr_load = 1'b1;
        end
      end

      ST_ALARM: begin
        if (bus.alarm_clr) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase

    // Mismatch and timeout share one failure path; the timer is parked at 0 on exit.
    if (fail_attempt) begin
      fail_d   = fail_inc;
      shift_d  = '0;
      count_d  = '0;
      tmr_load = 1'b1;
      tmr_val  = '0;
      state_d  = (fail_inc == FAIL_W'(MAX_TRIES)) ? ST_ALARM : ST_LOCKED;
    end
  end

  // State, datapath and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOCKED;
      shift_q <= '0;
      count_q <= '0;
      fail_q  <= '0;
      lock_q  <= 1'b1;
      al_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      fail_q  <= fail_d;
      lock_q  <= (state_d != ST_UNLOCKED);
      al_q    <= (state_d == ST_ALARM);
    end
  end

  assign bus.lock     = lock_q;
  assign bus.al       = al_q;
  assign bus.state    = state_q;
  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_access_controller.sv
// Scoreboard bench for access_controller: a cycle-indexed reference model predicts outputs.
module tb_access_controller;
  import access_pkg::*;

  localparam int unsigned P  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned MT = 3;
  localparam int unsigned EC = 60;
  localparam int unsigned UC = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  access_controller_if #(.PIN_DIGITS(P), .DIGIT_W(DW), .MAX_TRIES(MT)) bus ();

  access_controller #(
    .PIN_DIGITS    (P),
    .DIGIT_W       (DW),
    .MAX_TRIES     (MT),
    .ENTRY_CYCLES  (EC),
    .UNLOCK_CYCLES (UC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned st;
    int unsigned lock;
    int unsigned al;
    int unsigned fc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode, failure tally, collected digits and an absolute deadline.
  state_t      m_mode   = ST_LOCKED;
  int unsigned m_fails  = 0;
  int unsigned m_digits[$];
  longint      cyc      = 0;
  longint      m_deadline = 0;

  int checks = 0;
  int errors = 0;

  function automatic int unsigned pin_digit(input int unsigned i);
    logic [P*DW-1:0] t;
    t = bus.pin_code >> (DW * (P - 1 - i));
    return 32'(t[DW-1:0]);
  endfunction

  function automatic bit pin_ok();
    for (int i = 0; i < int'(P); i++)
      if (m_digits[i] != pin_digit(i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_fail();
    m_digits.delete();
    if (m_fails < MT) m_fails = m_fails + 1;
    m_mode = (m_fails == MT) ? ST_ALARM : ST_LOCKED;
  endtask

  task automatic start_entry();
    m_digits.delete();
    m_mode     = ST_ENTRY;
    m_deadline = cyc + EC;
  endtask

  task automatic model_step();
    bit          k, v, a, c;
    int unsigned d;
    k = bus.kc; v = bus.digit_valid; a = bus.arm; c = bus.alarm_clr;
    d = 32'(bus.digit);
    case (m_mode)
      ST_LOCKED:   if (k) start_entry();
      ST_ENTRY: begin
        if (k) start_entry();
        else if (v && m_digits.size() == P - 1) begin
          m_digits.push_back(d);
          if (pin_ok()) begin
            m_digits.delete();
            m_mode     = ST_UNLOCKED;
            m_fails    = 0;
            m_deadline = cyc + UC;
          end else model_fail();
        end
        else if (cyc == m_deadline) model_fail();
        else if (v) m_digits.push_back(d);
      end
      ST_UNLOCKED: if (a || cyc == m_deadline) m_mode = ST_LOCKED;
      ST_ALARM:    if (c) begin m_mode = ST_LOCKED; m_fails = 0; end
      default: ;
    endcase
  endtask

  // Advance the model at each sampling edge (or reset) and queue the predicted outputs.
  always @(posedge clk or negedge rst_n) begin : model_p
    exp_t e;
    if (!rst_n) begin
      m_mode  = ST_LOCKED;
      m_fails = 0;
      m_digits.delete();
      exp_q.delete();
    end else begin
      cyc = cyc + 1;
      model_step();
    end
    e.st   = 32'(m_mode);
    e.lock = (m_mode != ST_UNLOCKED) ? 1 : 0;
    e.al   = (m_mode == ST_ALARM) ? 1 : 0;
    e.fc   = m_fails;
    exp_q.push_back(e);
  end

  function automatic void chk(input string name, input int unsigned act, input int unsigned expv);
    checks = checks + 1;
    if (act != expv) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endfunction

  // Monitor: pop one prediction per output update and compare every output.
  always begin : mon_p
    exp_t e;
    @(negedge clk or negedge rst_n);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("state",    32'(bus.state),    e.st);
      chk("lock",     32'(bus.lock),     e.lock);
      chk("al",       32'(bus.al),       e.al);
      chk("fail_cnt", 32'(bus.fail_cnt), e.fc);
    end
  end

  task automatic drive(input bit k, input bit v, input int unsigned d, input bit a, input bit c);
    bus.kc = k; bus.digit_valid = v; bus.digit = DW'(d); bus.arm = a; bus.alarm_clr = c;
    @(posedge clk);
    #1;
    bus.kc = 1'b0; bus.digit_valid = 1'b0; bus.digit = '0; bus.arm = 1'b0; bus.alarm_clr = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic digits4(input int unsigned a, input int unsigned b,
                         input int unsigned c, input int unsigned d);
    drive(0, 1, a, 0, 0); drive(0, 1, b, 0, 0);
    drive(0, 1, c, 0, 0); drive(0, 1, d, 0, 0);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.kc = 1'b0; bus.digit_valid = 1'b0; bus.digit = '0;
    bus.arm = 1'b0; bus.alarm_clr = 1'b0; bus.pin_code = 16'h1234;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // correct PIN, then auto-relock after the unlock window
    drive(1, 0, 0, 0, 0); digits4(1, 2, 3, 4); idle(UC + 3);

    // three wrong entries raise the alarm; other inputs ignored; alarm_clr clears it
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0); digits4(1, 2, 3, 5); idle(2);
    end
    drive(1, 1, 1, 1, 0); idle(2);
    drive(0, 0, 0, 0, 1); idle(2);

    // incomplete entry times out as a failure
    drive(1, 0, 0, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 2, 0, 0); idle(EC + 3);

    // kc with digit in LOCKED drops the digit
    drive(1, 1, 1, 0, 0); digits4(1, 2, 3, 4); idle(3); drive(0, 0, 0, 1, 0); idle(2);

    // last digit on the timeout cycle, then arm coinciding with unlock expiry
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0); drive(0, 1, 2, 0, 0); drive(0, 1, 3, 0, 0);
    idle(EC - 4);
    drive(0, 1, 4, 0, 0);
    idle(UC - 1);
    drive(0, 0, 0, 1, 0); idle(2);

    // kc mid-entry restarts without counting a failure
    drive(1, 0, 0, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 2, 0, 0); drive(0, 1, 3, 0, 0);
    drive(1, 0, 0, 0, 0); digits4(1, 2, 3, 4); idle(2); drive(0, 0, 0, 1, 0); idle(2);

    // asynchronous reset during ENTRY, then a normal unlock
    drive(1, 0, 0, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 1, 2, 0, 0);
    pulse_reset();
    drive(1, 0, 0, 0, 0); digits4(1, 2, 3, 4); idle(2); drive(0, 0, 0, 1, 0); idle(2);

    // asynchronous reset during ALARM, then a normal unlock
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0); digits4(9, 9, 9, 9); idle(1);
    end
    idle(2);
    pulse_reset();
    drive(1, 0, 0, 0, 0); digits4(1, 2, 3, 4); idle(2); drive(0, 0, 0, 1, 0); idle(2);

    // randomized traffic biased towards correct digits
    for (int i = 0; i < 3000; i++) begin
      bit          k, v, a, c;
      int unsigned d;
      k = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 1) == 0);
      a = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) < 8 && m_digits.size() < P)
        d = pin_digit(m_digits.size());
      else
        d = $urandom_range(0, 15);
      drive(k, v, d, a, c);
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/access_controller.md
# access_controller

Clocked sequencing controller for the keycard/PIN/lock alarm path: collects a keycard presentation and a multi-digit PIN, compares it against a configured code, drives the door lock and the alarm, and enforces a failed-attempt lockout. Sits between the keypad/card-reader front end and the lock actuator. It replaces the purely combinational KC/PIN/LOCK → AL decision with a stateful, timed controller.

## Interface
Parameters:
- PIN_DIGITS, 4, number of digits per PIN entry
- DIGIT_W, 4, width of one digit
- MAX_TRIES, 3, consecutive failures that raise the alarm
- ENTRY_CYCLES, 1000, max cycles from card to last digit
- UNLOCK_CYCLES, 500, cycles door stays unlocked before auto-relock

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- kc  in  1  keycard presented, one-cycle pulse
- digit_valid  in  1  digit strobe, one-cycle pulse
- digit  in  DIGIT_W  keypad digit, sampled when digit_valid=1
- pin_code  in  PIN_DIGITS*DIGIT_W  configured code, first digit in MSBs, static during ENTRY
- arm  in  1  relock request pulse
- alarm_clr  in  1  supervisor alarm clear pulse
- lock  out  1  1 = door locked
- al  out  1  1 = alarm active
- state  out  3  current FSM state (encoding in access_pkg)
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failed attempts

## Operation
- All outputs registered. Reset values: state=LOCKED, lock=1, al=0, fail_cnt=0, digit count 0, timers 0.
- LOCKED: lock=1, al=0. kc → ENTRY, clear digit count and shift register, load entry timer with ENTRY_CYCLES. digit_valid without prior kc ignored. kc and digit_valid in the same cycle: kc wins, digit discarded.
- ENTRY: each digit_valid shifts digit into the shift register (MSB first) and increments digit count. On the PIN_DIGITS-th digit, compare {shifted value including that digit} against pin_code:
  - match → UNLOCKED, fail_cnt=0, unlock timer loaded with UNLOCK_CYCLES.
  - mismatch → fail_cnt+1; if new fail_cnt == MAX_TRIES → ALARM, else → LOCKED.
- Entry timer expiry in ENTRY counts as a mismatch (same fail_cnt/ALARM rule). Last digit and timer expiry in the same cycle: digit wins, compare result used.
- kc during ENTRY restarts entry (clear digits, reload timer); not a failure.
- UNLOCKED: lock=0. arm pulse or unlock timer expiry → LOCKED next cycle. Both same cycle → LOCKED. kc/digits ignored.
- ALARM: lock=1, al=1. Only alarm_clr exits → LOCKED, fail_cnt=0. All other inputs ignored.
- fail_cnt saturates at MAX_TRIES; only cleared by a match, alarm_clr or reset.
- Reset mid-operation: immediate return to reset values regardless of state; partial PIN discarded.

## Timing
- Event sampled at edge N → state and outputs updated at edge N+1 (one-cycle latency). Last matching digit at N → lock=0 from N+1.
- Entry timeout: ENTRY entered at edge N → failure taken at edge N+ENTRY_CYCLES if PIN incomplete.
- Unlock: UNLOCKED entered at edge N → lock=1 again at edge N+UNLOCK_CYCLES absent arm.
- Timers are down-counters, width $clog2(max(ENTRY_CYCLES,UNLOCK_CYCLES)+1); expire on reaching 1 → transition; no wrap.
- All input pulses are assumed one cycle wide; a held level counts once per cycle high.

## Structure
- access_pkg: state enum (LOCKED, ENTRY, UNLOCKED, ALARM), state width constant 3, default parameter constants.
- One sub-module: access_timer (load value, load strobe, expired flag), shared between entry and unlock timing since the two are never active at once.
- FSM, digit shift register, comparator and fail counter in access_controller.

## Test plan
- Reset, kc, digits 1,2,3,4 with pin_code=16'h1234 → lock=0 one cycle after 4th digit, fail_cnt=0; lock=1 again UNLOCK_CYCLES later.
- Three wrong entries (1,2,3,5) → fail_cnt 1,2 then state=ALARM, al=1, lock=1; alarm_clr → LOCKED, al=0, fail_cnt=0.
- kc then 2 digits, no more input → failure at ENTRY_CYCLES, fail_cnt=1, state=LOCKED.
- Simultaneous cases: kc+digit_valid in LOCKED → digit dropped; 4th digit on timeout cycle → match unlocks; arm+unlock expiry → LOCKED.
- kc mid-entry after 3 digits, then correct 4 digits → unlock, fail_cnt unchanged at 0.
- rst_n asserted asynchronously in ENTRY and in ALARM → outputs at reset values immediately, next correct PIN unlocks normally.
